// File: rtl/imm_bus_pkg.sv
// Shared types and widths for the split immediate bus receiver.
package imm_bus_pkg;

    localparam int WORD_W = 32;
    localparam int HI_W   = 4;
    localparam int LO_W   = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_HI = 2'd1,
        GOT_LO = 2'd2,
        FULL   = 2'd3
    } state_t;

    // State reached from an empty buffer given which lanes rose this cycle.
    function automatic state_t capture_state(input logic hi_rise, input logic lo_rise);
        case ({hi_rise, lo_rise})
            2'b11:   return FULL;
            2'b10:   return GOT_HI;
            2'b01:   return GOT_LO;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/oe_rise_det.sv
// Registered rising-edge detector for a level output-enable strobe.
module oe_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic oe,
    output logic rise
);

    logic oe_q;

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oe_q <= 1'b0;
        else        oe_q <= oe;
    end

    assign rise = oe & ~oe_q;

endmodule

// File: rtl/imm_bus_collector.sv
// Reassembles the split immediate bus into a 32-bit operand behind a valid/ready handshake.
// Optional partial-word abort timer enabled by defining IMM_TIMEOUT_EN.
module imm_bus_collector #(
    parameter int HI_W = imm_bus_pkg::HI_W,
    parameter int LO_W = imm_bus_pkg::LO_W
`ifdef IMM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [HI_W-1:0]              hi_lane,
    input  logic                         hi_oe,
    input  logic [LO_W-1:0]              lo_lane,
    input  logic                         lo_oe,
    input  logic                         clr,
    output logic [imm_bus_pkg::WORD_W-1:0] word_o,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         partial,
    output logic                         overrun,
    output logic                         timeout
);

    import imm_bus_pkg::state_t;
    import imm_bus_pkg::capture_state;
    import imm_bus_pkg::IDLE;
    import imm_bus_pkg::GOT_HI;
    import imm_bus_pkg::GOT_LO;
    import imm_bus_pkg::FULL;

    state_t            state_q, state_d;
    logic              hi_rise, lo_rise;
    logic              cap_hi, cap_lo, ovr_set;
    logic [HI_W-1:0]   hi_q;
    logic [LO_W-1:0]   lo_q;

    oe_rise_det u_hi_det (.clk(clk), .rst_n(rst_n), .oe(hi_oe), .rise(hi_rise));
    oe_rise_det u_lo_det (.clk(clk), .rst_n(rst_n), .oe(lo_oe), .rise(lo_rise));

`ifdef IMM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             at_limit, expire;

    assign at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        cap_hi  = 1'b0;
        cap_lo  = 1'b0;
        ovr_set = 1'b0;
`ifdef IMM_TIMEOUT_EN
        expire  = 1'b0;
`endif
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cap_hi  = hi_rise;
                    cap_lo  = lo_rise;
                    state_d = capture_state(hi_rise, lo_rise);
                end
                GOT_HI, GOT_LO: begin
                    // A repeat rise on the held lane overwrites it; the other lane completes the word.
                    cap_hi = hi_rise;
                    cap_lo = lo_rise;
                    if ((state_q == GOT_HI) ? lo_rise : hi_rise) begin
                        state_d = FULL;
`ifdef IMM_TIMEOUT_EN
                    end else if (!hi_rise && !lo_rise && at_limit) begin
                        state_d = IDLE;
                        expire  = 1'b1;
`endif
                    end
                end
                FULL: begin
                    if (word_ready) begin
                        cap_hi  = hi_rise;
                        cap_lo  = lo_rise;
                        state_d = capture_state(hi_rise, lo_rise);
                    end else begin
                        ovr_set = hi_rise | lo_rise;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        word_valid = (state_q == FULL);
        partial    = (state_q == GOT_HI) || (state_q == GOT_LO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            overrun <= 1'b0;
        end else if (clr) begin
            hi_q    <= '0;
            lo_q    <= '0;
            overrun <= 1'b0;
        end else begin
            if (cap_hi)  hi_q    <= hi_lane;
            if (cap_lo)  lo_q    <= lo_lane;
            if (ovr_set) overrun <= 1'b1;
        end
    end

    assign word_o = {hi_q, lo_q};

`ifdef IMM_TIMEOUT_EN
    // Counter restarts on any capture and idles at zero outside the partial states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (clr || cap_hi || cap_lo || state_d == IDLE || state_d == FULL) cnt_q <= '0;
            else                                                               cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_imm_bus_collector.sv
// Scoreboard bench for imm_bus_collector; timeout checks follow IMM_TIMEOUT_EN.
module tb_imm_bus_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  hi_lane = 4'h0;
    logic        hi_oe = 1'b0;
    logic [27:0] lo_lane = 28'h0;
    logic        lo_oe = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] word_o;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        partial;
    logic        overrun;
    logic        timeout;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];

    imm_bus_collector dut (
        .clk(clk), .rst_n(rst_n),
        .hi_lane(hi_lane), .hi_oe(hi_oe),
        .lo_lane(lo_lane), .lo_oe(lo_oe),
        .clr(clr),
        .word_o(word_o), .word_valid(word_valid), .word_ready(word_ready),
        .partial(partial), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare each word the consumer accepts against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (sb.size() == 0) check("unexpected_word", word_o, 32'hxxxxxxxx);
            else                check("sb_word", word_o, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the selected strobes for one edge, then drop them and let the lanes float.
    task automatic drive(input bit h, input logic [3:0] hd, input bit l, input logic [27:0] ld);
        if (h) begin hi_lane = hd; hi_oe = 1'b1; end
        if (l) begin lo_lane = ld; lo_oe = 1'b1; end
        tick();
        hi_oe   = 1'b0;
        lo_oe   = 1'b0;
        hi_lane = 4'($urandom);
        lo_lane = 28'($urandom);
    endtask

    task automatic check_flags(input string tag, input bit v, input bit p, input bit o);
        check({tag, "_valid"},   {31'd0, word_valid}, {31'd0, v});
        check({tag, "_partial"}, {31'd0, partial},    {31'd0, p});
        check({tag, "_overrun"}, {31'd0, overrun},    {31'd0, o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen_at;
        int pulses;

        // Reset state
        #12;
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_word", word_o, 32'h0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: hi first, lo three cycles later, consumer ready
        word_ready = 1'b1;
        drive(1, 4'hA, 0, 28'h0);
        check_flags("t1_hi", 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        sb.push_back(32'hA1234567);
        drive(0, 4'h0, 1, 28'h1234567);
        check_flags("t1_full", 1'b1, 1'b0, 1'b0);
        check("t1_word", word_o, 32'hA1234567);
        tick();
        check("t1_valid_one_cycle", {31'd0, word_valid}, 32'd0);

        // 2: both lanes together, consumer stalls, late hi rise overruns
        word_ready = 1'b0;
        sb.push_back(32'hFFFFFFFE);
        drive(1, 4'hF, 1, 28'hFFFFFFE);
        check_flags("t2_full", 1'b1, 1'b0, 1'b0);
        tick();
        drive(1, 4'h3, 0, 28'h0);
        check_flags("t2_ovr", 1'b1, 1'b0, 1'b1);
        check("t2_word_held", word_o, 32'hFFFFFFFE);
        tick();
        tick();
        check("t2_word_stable", word_o, 32'hFFFFFFFE);
        word_ready = 1'b1;
        tick();
        check_flags("t2_drained", 1'b0, 1'b0, 1'b1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_flags("t2_clr", 1'b0, 1'b0, 1'b0);

        // 3: lo overwritten before hi arrives
        drive(0, 4'h0, 1, 28'h0000010);
        tick();
        check_flags("t3_lo", 1'b0, 1'b1, 1'b0);
        drive(0, 4'h0, 1, 28'h0000020);
        tick();
        sb.push_back(32'h00000020);
        drive(1, 4'h0, 0, 28'h0);
        check("t3_word", word_o, 32'h00000020);
        tick();

        // 4: transfer and new hi rise on the same edge
        word_ready = 1'b0;
        sb.push_back(32'h10000001);
        drive(1, 4'h1, 1, 28'h0000001);
        tick();
        word_ready = 1'b1;
        drive(1, 4'h3, 0, 28'h0);
        check_flags("t4_got_hi", 1'b0, 1'b1, 1'b0);
        tick();
        sb.push_back(32'h300000AB);
        drive(0, 4'h0, 1, 28'h00000AB);
        check("t4_word", word_o, 32'h300000AB);
        tick();

        // 5: clr beats a simultaneous lo rise in GOT_HI
        drive(1, 4'h7, 0, 28'h0);
        tick();
        clr   = 1'b1;
        lo_oe = 1'b1;
        lo_lane = 28'h0000099;
        tick();
        clr   = 1'b0;
        lo_oe = 1'b0;
        check_flags("t5_clr", 1'b0, 1'b0, 1'b0);
        check("t5_word_zero", word_o, 32'h0);
        tick();

        // 6a: hi only, then wait for the abort timer
        drive(1, 4'h9, 0, 28'h0);
        seen_at = 0;
        pulses  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (timeout) begin
                pulses++;
                if (seen_at == 0) begin
                    seen_at = i;
                    check("t6_partial_at_timeout", {31'd0, partial}, 32'd0);
                end
            end
        end
`ifdef IMM_TIMEOUT_EN
        check("t6_timeout_cycle", seen_at, 32'd16);
        check("t6_timeout_pulses", pulses, 32'd1);
        check("t6_partial_after", {31'd0, partial}, 32'd0);
`else
        check("t6_timeout_pulses", pulses, 32'd0);
        check("t6_partial_held", {31'd0, partial}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
`endif

        // 6b: second lane arrives on the expiry edge and wins
        drive(1, 4'hC, 0, 28'h0);
        for (int i = 0; i < 15; i++) tick();
        sb.push_back(32'hC0000BEE);
        drive(0, 4'h0, 1, 28'h0000BEE);
        check("t6b_valid", {31'd0, word_valid}, 32'd1);
        check("t6b_timeout", {31'd0, timeout}, 32'd0);
        check("t6b_word", word_o, 32'hC0000BEE);
        tick();

        // 6c: async reset while holding lo
        drive(0, 4'h0, 1, 28'h0000055);
        check("t6c_partial", {31'd0, partial}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_flags("t6c_rst", 1'b0, 1'b0, 1'b0);
        check("t6c_word", word_o, 32'h0);
        check("t6c_timeout", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
